// File: rtl/return_addr_stack_ckpt.sv
// Circular return address stack with single-cycle checkpoint restore.
// Overflow overwrites the oldest entry, and popped entries are retained for recovery.
module return_addr_stack_ckpt #(
   parameter  int ENTRY_NUM  = 4,
   parameter  int ADDR_WIDTH = 32,
   localparam int PTR_WIDTH  = $clog2(ENTRY_NUM),
   localparam int CNT_WIDTH  = $clog2(ENTRY_NUM + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [ADDR_WIDTH-1:0] pushAddr,
   input  logic                  pop,
   input  logic                  recover,
   input  logic [PTR_WIDTH-1:0]  recoverPtr,
   input  logic [CNT_WIDTH-1:0]  recoverCount,
   input  logic [ADDR_WIDTH-1:0] recoverTopAddr,
   output logic [ADDR_WIDTH-1:0] topAddr,
   output logic                  topValid,
   output logic [PTR_WIDTH-1:0]  ptrOut,
   output logic [CNT_WIDTH-1:0]  countOut,
   output logic                  overflow,
   output logic                  underflow
);

   localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(ENTRY_NUM);
   localparam logic [PTR_WIDTH-1:0] PTR_ONE    = PTR_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

   logic [ADDR_WIDTH-1:0] entries [ENTRY_NUM];
   logic [PTR_WIDTH-1:0]  ptr;
   logic [CNT_WIDTH-1:0]  count;

   logic [PTR_WIDTH-1:0]  ptr_nxt;
   logic [CNT_WIDTH-1:0]  count_nxt;
   logic                  wr_en;
   logic [PTR_WIDTH-1:0]  wr_idx;
   logic [ADDR_WIDTH-1:0] wr_data;
   logic                  overflow_nxt;
   logic                  underflow_nxt;

   logic                  is_empty;
   logic                  is_full;
   logic [PTR_WIDTH-1:0]  ptr_inc;
   logic [PTR_WIDTH-1:0]  ptr_dec;

   assign is_empty = (count == '0);
   assign is_full  = (count == FULL_COUNT);
   assign ptr_inc  = ptr + PTR_ONE;
   assign ptr_dec  = ptr - PTR_ONE;

   always_comb begin
      ptr_nxt       = ptr;
      count_nxt     = count;
      wr_en         = 1'b0;
      wr_idx        = ptr;
      wr_data       = pushAddr;
      overflow_nxt  = 1'b0;
      underflow_nxt = 1'b0;

      if (recover) begin
         ptr_nxt   = recoverPtr;
         count_nxt = recoverCount;
         // An empty checkpoint carries no meaningful top; leave the array alone.
         wr_en     = (recoverCount != '0);
         wr_idx    = recoverPtr;
         wr_data   = recoverTopAddr;
      end else if (push && pop) begin
         // Return-then-call replaces the top in place.
         wr_en     = 1'b1;
         wr_idx    = ptr;
         count_nxt = is_empty ? CNT_ONE : count;
      end else if (push) begin
         ptr_nxt      = ptr_inc;
         wr_en        = 1'b1;
         wr_idx       = ptr_inc;
         count_nxt    = is_full ? count : count + CNT_ONE;
         overflow_nxt = is_full;
      end else if (pop) begin
         if (is_empty) begin
            underflow_nxt = 1'b1;
         end else begin
            ptr_nxt   = ptr_dec;
            count_nxt = count - CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr       <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         for (int i = 0; i < ENTRY_NUM; i++) begin
            entries[i] <= '0;
         end
      end else begin
         ptr       <= ptr_nxt;
         count     <= count_nxt;
         overflow  <= overflow_nxt;
         underflow <= underflow_nxt;
         if (wr_en) begin
            entries[wr_idx] <= wr_data;
         end
      end
   end

   assign topAddr  = entries[ptr];
   assign topValid = !is_empty;
   assign ptrOut   = ptr;
   assign countOut = count;

   recover_count_legal: assert property (@(posedge clk) disable iff (rst)
      recover |-> (recoverCount <= FULL_COUNT))
      else $error("recoverCount %0d exceeds ENTRY_NUM %0d", recoverCount, ENTRY_NUM);

endmodule

// File: tb/tb_return_addr_stack_ckpt.sv
// Directed self-checking bench for return_addr_stack_ckpt with ENTRY_NUM=4, ADDR_WIDTH=32.
module tb_return_addr_stack_ckpt;

   logic        clk;
   logic        rst;
   logic        push;
   logic [31:0] pushAddr;
   logic        pop;
   logic        recover;
   logic [1:0]  recoverPtr;
   logic [2:0]  recoverCount;
   logic [31:0] recoverTopAddr;
   logic [31:0] topAddr;
   logic        topValid;
   logic [1:0]  ptrOut;
   logic [2:0]  countOut;
   logic        overflow;
   logic        underflow;

   int passed;
   int total;

   return_addr_stack_ckpt #(.ENTRY_NUM(4), .ADDR_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .push(push), .pushAddr(pushAddr), .pop(pop),
      .recover(recover), .recoverPtr(recoverPtr), .recoverCount(recoverCount),
      .recoverTopAddr(recoverTopAddr), .topAddr(topAddr), .topValid(topValid),
      .ptrOut(ptrOut), .countOut(countOut), .overflow(overflow), .underflow(underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      push    = 1'b0;
      pop     = 1'b0;
      recover = 1'b0;
   endtask

   task automatic do_push(input logic [31:0] a);
      push = 1'b1; pushAddr = a; cyc();
   endtask

   task automatic do_pop();
      pop = 1'b1; cyc();
   endtask

   task automatic do_reset();
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
   endtask

   initial begin
      passed = 0; total = 0;
      rst = 1'b1; push = 1'b0; pop = 1'b0; recover = 1'b0; pushAddr = '0;
      recoverPtr = '0; recoverCount = '0; recoverTopAddr = '0;
      #12 rst = 1'b0;

      // Reset state and underflow on empty pop
      cyc();
      check("rst_topValid", {31'd0, topValid}, 32'd0);
      check("rst_count", {29'd0, countOut}, 32'd0);
      check("rst_ptr", {30'd0, ptrOut}, 32'd0);
      check("rst_top", topAddr, 32'h0);
      check("rst_ovf", {31'd0, overflow}, 32'd0);
      do_pop();
      check("udf_pulse", {31'd0, underflow}, 32'd1);
      check("udf_count", {29'd0, countOut}, 32'd0);
      check("udf_ptr", {30'd0, ptrOut}, 32'd0);
      cyc();
      check("udf_clear", {31'd0, underflow}, 32'd0);

      // Fill then drain
      do_push(32'h100); check("push1_top", topAddr, 32'h100);
      check("push1_ptr", {30'd0, ptrOut}, 32'd1);
      do_push(32'h200); do_push(32'h300); do_push(32'h400);
      check("fill_count", {29'd0, countOut}, 32'd4);
      check("fill_ptr", {30'd0, ptrOut}, 32'd0);
      check("fill_top", topAddr, 32'h400);
      check("fill_noovf", {31'd0, overflow}, 32'd0);
      do_pop(); check("drain_top1", topAddr, 32'h300);
      do_pop(); check("drain_top2", topAddr, 32'h200);
      do_pop(); check("drain_top3", topAddr, 32'h100);
      check("drain_cnt3", {29'd0, countOut}, 32'd1);
      do_pop(); check("drain_count", {29'd0, countOut}, 32'd0);
      check("drain_valid", {31'd0, topValid}, 32'd0);

      // Overflow wrap
      do_push(32'h100); do_push(32'h200); do_push(32'h300); do_push(32'h400);
      check("ovf_before", {31'd0, overflow}, 32'd0);
      do_push(32'h500);
      check("ovf_pulse", {31'd0, overflow}, 32'd1);
      check("ovf_count", {29'd0, countOut}, 32'd4);
      check("ovf_top", topAddr, 32'h500);
      check("ovf_ptr", {30'd0, ptrOut}, 32'd1);
      do_pop(); check("wrap_top1", topAddr, 32'h400);
      check("ovf_clear", {31'd0, overflow}, 32'd0);
      do_pop(); check("wrap_top2", topAddr, 32'h300);
      do_pop(); check("wrap_top3", topAddr, 32'h200);
      do_pop(); check("wrap_valid", {31'd0, topValid}, 32'd0);
      do_pop(); check("wrap_udf", {31'd0, underflow}, 32'd1);
      check("wrap_udf_ptr", {30'd0, ptrOut}, 32'd1);

      // push&pop on empty stack
      push = 1'b1; pop = 1'b1; pushAddr = 32'h55; cyc();
      check("pp_empty_count", {29'd0, countOut}, 32'd1);
      check("pp_empty_ptr", {30'd0, ptrOut}, 32'd1);
      check("pp_empty_top", topAddr, 32'h55);
      check("pp_empty_udf", {31'd0, underflow}, 32'd0);

      // push&pop replaces top
      do_reset();
      do_push(32'hA0); do_push(32'hB0);
      push = 1'b1; pop = 1'b1; pushAddr = 32'hC0; cyc();
      check("pp_count", {29'd0, countOut}, 32'd2);
      check("pp_ptr", {30'd0, ptrOut}, 32'd2);
      check("pp_top", topAddr, 32'hC0);
      do_pop(); check("pp_pop_top", topAddr, 32'hA0);

      // Checkpoint and recover, recover beats push
      do_reset();
      do_push(32'hA0); do_push(32'hB0);
      check("ck_ptr", {30'd0, ptrOut}, 32'd2);
      check("ck_top", topAddr, 32'hB0);
      do_push(32'hD0); do_push(32'hE0); do_pop();
      check("ck_mid_top", topAddr, 32'hD0);
      recover = 1'b1; recoverPtr = 2'd2; recoverCount = 3'd2; recoverTopAddr = 32'hB0;
      push = 1'b1; pushAddr = 32'hF0; cyc();
      check("rc_ptr", {30'd0, ptrOut}, 32'd2);
      check("rc_count", {29'd0, countOut}, 32'd2);
      check("rc_top", topAddr, 32'hB0);
      do_pop(); check("rc_pop_top", topAddr, 32'hA0);
      recover = 1'b1; recoverPtr = 2'd3; recoverCount = 3'd0; recoverTopAddr = 32'h99; cyc();
      check("rc0_valid", {31'd0, topValid}, 32'd0);
      check("rc0_top_kept", topAddr, 32'hD0);

      // Asynchronous reset mid-cycle
      do_reset();
      do_push(32'h11); do_push(32'h22); do_push(32'h33);
      check("ar_count_pre", {29'd0, countOut}, 32'd3);
      @(negedge clk); #2 rst = 1'b1;
      #1;
      check("ar_count", {29'd0, countOut}, 32'd0);
      check("ar_ptr", {30'd0, ptrOut}, 32'd0);
      check("ar_top", topAddr, 32'h0);
      check("ar_valid", {31'd0, topValid}, 32'd0);
      #1 rst = 1'b0;
      do_push(32'h77);
      check("ar_push_ptr", {30'd0, ptrOut}, 32'd1);
      check("ar_push_top", topAddr, 32'h77);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/return_addr_stack_ckpt.md
Name: return_addr_stack_ckpt

Overview:
- Parametrised successor to the fixed 4-entry return address stack (RAS) in the branch-prediction front end.
- Circular stack with configurable depth and address width; overflow wraps by overwriting the oldest entry.
- Exports pointer, count and top address so the fetch stage can checkpoint them per branch, and restores all three in one cycle on misprediction recovery.
- Sits beside the BTB/PHT in the fetch stage; fed by call/return detection, recovered by the back end.

Parameters:
ENTRY_NUM  4   number of stack entries; power of two, >= 2 (CONF_RAS_ENTRY_NUM)
ADDR_WIDTH  32  width of a stored return address
PTR_WIDTH  $clog2(ENTRY_NUM)  derived, not overridable
CNT_WIDTH  $clog2(ENTRY_NUM+1)  derived, not overridable

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
push  in  1  call detected: push pushAddr
pushAddr  in  ADDR_WIDTH  return address to push
pop  in  1  return detected: pop top
recover  in  1  restore checkpointed state; overrides push/pop
recoverPtr  in  PTR_WIDTH  checkpointed top pointer
recoverCount  in  CNT_WIDTH  checkpointed occupancy, 0..ENTRY_NUM
recoverTopAddr  in  ADDR_WIDTH  checkpointed top-entry contents
topAddr  out  ADDR_WIDTH  entry[ptr]; predicted return target
topValid  out  1  count != 0
ptrOut  out  PTR_WIDTH  current top pointer, for checkpointing
countOut  out  CNT_WIDTH  current occupancy, for checkpointing
overflow  out  1  registered one-cycle pulse: the previous cycle's push overwrote the oldest entry
underflow  out  1  registered one-cycle pulse: the previous cycle's pop found the stack empty

Behaviour:
- Reset clock and polarity: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: ptr=0, count=0, all entries=0, overflow=0, underflow=0.
  - Hence topAddr=0, topValid=0, ptrOut=0, countOut=0.
  - Reset asserted mid-operation discards any pending op immediately.
- State: entry[ENTRY_NUM], ptr, count, all updated on rising clk.
- Outputs:
  - topAddr, topValid, ptrOut and countOut are combinational from the current state only; no input-to-output path.
  - A push is visible on topAddr the next cycle (1-cycle latency).
- Priority per cycle: recover > (push & pop) > push > pop > idle.
- recover:
  - ptr<=recoverPtr, count<=recoverCount.
  - If recoverCount!=0, entry[recoverPtr]<=recoverTopAddr.
  - Other entries unchanged; overflow/underflow<=0.
  - recoverCount>ENTRY_NUM is illegal; an assertion fires.
- push only:
  - ptr<=(ptr+1) mod ENTRY_NUM (natural PTR_WIDTH wrap); entry[ptr+1]<=pushAddr.
  - count<=min(count+1, ENTRY_NUM).
  - overflow<=1 iff count==ENTRY_NUM before the push (oldest entry lost).
- pop only:
  - If count!=0: ptr<=ptr-1 mod ENTRY_NUM; count<=count-1; entries unchanged.
  - If count==0: state unchanged; underflow<=1.
- push & pop (return-then-call, e.g. jalr with link):
  - entry[ptr]<=pushAddr; ptr unchanged.
  - count<=(count==0)?1:count; no overflow/underflow.
- Idle: state held; overflow/underflow<=0.
- Pulses: overflow and underflow are high for exactly one cycle after the causing edge.
- Wrap-around: after more than ENTRY_NUM pushes, successive pops return the newest ENTRY_NUM addresses in LIFO order. count reaches 0 after ENTRY_NUM pops; further pops underflow.
- Popped entries are not cleared: a recover to an older ptr sees the original data underneath the restored top.

Test Plan:
- Reset then idle -> topValid=0, countOut=0, ptrOut=0, topAddr=0; pop -> underflow=1 for one cycle, state unchanged.
- ENTRY_NUM=4: push 0x100,0x200,0x300,0x400 -> countOut=4, ptrOut=0, topAddr=0x400; pop x4 -> topAddr 0x300,0x200,0x100 in turn, countOut=0 at end.
- Push 0x100..0x500 (5 pushes) -> overflow pulses after the 5th push, countOut=4, topAddr=0x500; pop x4 -> tops 0x400,0x300,0x200, then topValid=0.
- Push 0xA0,0xB0; push&pop with 0xC0 -> countOut=2, ptrOut unchanged, topAddr=0xC0; pop -> topAddr=0xA0.
- Checkpoint (ptr=2,count=2,top=0xB0) after pushing 0xA0,0xB0; push 0xD0,0xE0, pop; recover with checkpoint in the same cycle as push 0xF0 -> push ignored, next cycle ptrOut=2, countOut=2, topAddr=0xB0; pop -> topAddr=0xA0.
- Assert rst asynchronously mid-clock while count=3 -> outputs drop to reset values before the next clk edge; first push after release lands at ptr=1.
